// File: rtl/sw_arb_pkg.sv
// Shared types and helpers for the packet-aware crossbar output arbiters.
package sw_arb_pkg;

  // Widest supported requester count; helpers are sized to this.
  localparam int MAX_N = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_e;

  // Binary index of a one-hot vector; returns 0 for an all-zero vector.
  function automatic int unsigned onehot2bin(input logic [MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first set request at or above ptr, wrapping.
module rr_prio_enc #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner_onehot,
  output logic             any
);

  assign any = |req;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    int   idx;
    logic found;
    winner_onehot = '0;
    found         = 1'b0;
    idx           = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        winner_onehot[idx] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_wrr_arb.sv
// Packet-aware weighted round-robin arbiter for one crossbar output.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no grant; arbitrate among ports presenting a sop beat
//   PKT   | grant held on r_cur until its eop beat transfers
module pkt_wrr_arb
  import sw_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WGT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0]         req_sop,
  input  logic [N-1:0]         req_eop,
  input  logic                 out_ready,
  input  logic [N*WGT_W-1:0]   cfg_weight,
  output logic [N-1:0]         in_ready,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 pkt_active,
  output logic                 sop_err
);

  localparam int IDX_W = $clog2(N);

  arb_state_e       r_state, w_state_nxt;
  logic [N-1:0]     r_grant, w_grant_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_cur, w_cur_nxt;
  logic [WGT_W-1:0] r_credit, w_credit_nxt;
  logic             r_first, w_first_nxt;
  logic             r_sop_err, w_sop_err_nxt;

  logic [N-1:0]     w_elig;
  logic [N-1:0]     w_win_oh;
  logic             w_any;
  logic [MAX_N-1:0] w_win_oh16;
  logic [MAX_N-1:0] w_grant16;
  logic [IDX_W-1:0] w_win_idx;
  logic [WGT_W-1:0] w_win_wgt;
  logic [WGT_W-1:0] w_credit_dec;
  logic             w_xfer;

  assign w_elig = req_valid & req_sop;

  rr_prio_enc #(
    .N     (N),
    .PTR_W (IDX_W)
  ) u_prio (
    .req           (w_elig),
    .ptr           (r_ptr),
    .winner_onehot (w_win_oh),
    .any           (w_any)
  );

  // Zero-extend one-hot vectors to the helper's fixed width.
  always_comb begin
    w_win_oh16          = '0;
    w_win_oh16[N-1:0]   = w_win_oh;
    w_grant16           = '0;
    w_grant16[N-1:0]    = r_grant;
  end

  assign w_win_idx    = IDX_W'(onehot2bin(w_win_oh16));
  assign w_win_wgt    = cfg_weight[int'(w_win_idx)*WGT_W +: WGT_W];
  assign w_xfer       = (r_state == PKT) & req_valid[r_cur] & out_ready;
  assign w_credit_dec = (r_credit > WGT_W'(1)) ? r_credit - WGT_W'(1) : '0;

  // Next-state, grant, credit and pointer updates.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_cur_nxt     = r_cur;
    w_credit_nxt  = r_credit;
    w_first_nxt   = r_first;
    w_sop_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = PKT;
          w_grant_nxt = w_win_oh;
          w_first_nxt = 1'b1;
          // A new owner, or an owner whose turn was used up, gets a fresh turn.
          if ((w_win_idx != r_cur) || (r_credit == '0)) begin
            w_cur_nxt    = w_win_idx;
            w_credit_nxt = (w_win_wgt == '0) ? WGT_W'(1) : w_win_wgt;
          end
        end else if (|req_valid) begin
          w_sop_err_nxt = 1'b1;
        end
      end
      PKT: begin
        if (w_xfer) begin
          w_first_nxt = 1'b0;
          if (req_sop[r_cur] && !r_first) w_sop_err_nxt = 1'b1;
          if (req_eop[r_cur]) begin
            w_state_nxt  = IDLE;
            w_grant_nxt  = '0;
            w_credit_nxt = w_credit_dec;
            if (w_credit_dec == '0)
              w_ptr_nxt = (r_cur == IDX_W'(N-1)) ? '0 : r_cur + 1'b1;
            else
              w_ptr_nxt = r_cur;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_cur     <= '0;
      r_credit  <= '0;
      r_first   <= 1'b0;
      r_sop_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cur     <= w_cur_nxt;
      r_credit  <= w_credit_nxt;
      r_first   <= w_first_nxt;
      r_sop_err <= w_sop_err_nxt;
    end
  end

  assign in_ready   = r_grant & {N{out_ready}};
  assign grant      = r_grant;
  assign grant_idx  = IDX_W'(onehot2bin(w_grant16));
  assign pkt_active = (r_state == PKT);
  assign sop_err    = r_sop_err;

endmodule
